// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage.
// Issues one level-sensitive read per instruction (REQ), then drops the request
// for one cycle (GAP) so every request starts with a fresh rising edge. A response
// that lands while decode is stalled is parked in a one-entry buffer. A flush to a
// misaligned target parks the unit in HALT with exception[0] set.
// Optional feature: define FETCH_TRACE_EN to print each instruction handed to decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] PC,
   output logic [31:0] instr,
   output logic        pipeline_valid,
   output logic        mem_rd_enable,
   output logic [31:0] mem_rd_addr,
   input  logic        mem_rd_ready,
   input  logic [31:0] mem_rd_data,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] flush_addr,
   output logic [1:0]  exception
);

   typedef enum logic [1:0] {StReq, StGap, StHalt} state_t;

   state_t      state_q;
   logic [31:0] fetch_pc_q;
   logic        buf_valid_q;
   logic [31:0] buf_pc_q;
   logic [31:0] buf_instr_q;

   logic        take_rsp;
   logic        flush_aligned;
   logic        load_buf;
   logic        load_mem;
   logic        load_out;
   logic [31:0] load_pc;
   logic [31:0] load_instr;
   logic [31:0] fetch_pc_inc;

   // Decode which source (if any) feeds the decode-facing registers this edge.
   always_comb begin
      take_rsp      = (state_q == StReq) && mem_rd_ready;
      flush_aligned = (flush_addr[1:0] == 2'b00);
      fetch_pc_inc  = fetch_pc_q + 32'd4;
      // The buffer and a live request are mutually exclusive; buffer wins regardless.
      load_buf      = !flush && !stall && buf_valid_q;
      load_mem      = !flush && !stall && take_rsp && !buf_valid_q;
      load_out      = load_buf || load_mem;
      load_pc       = buf_valid_q ? buf_pc_q : fetch_pc_q;
      load_instr    = buf_valid_q ? buf_instr_q : mem_rd_data;
   end

   // Fetch FSM with registered memory request and decode outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StGap;
         fetch_pc_q     <= RESET_PC;
         PC             <= 32'h0;
         instr          <= 32'h0;
         pipeline_valid <= 1'b0;
         mem_rd_enable  <= 1'b0;
         mem_rd_addr    <= 32'h0;
         exception      <= 2'b00;
         buf_valid_q    <= 1'b0;
         buf_pc_q       <= 32'h0;
         buf_instr_q    <= 32'h0;
      end else if (flush) begin
         // Redirect beats stall and any response arriving on this edge.
         pipeline_valid <= 1'b0;
         buf_valid_q    <= 1'b0;
         fetch_pc_q     <= flush_addr;
         mem_rd_enable  <= 1'b0;
         if (flush_aligned) begin
            state_q   <= StGap;
            exception <= 2'b00;
         end else begin
            state_q   <= StHalt;
            exception <= 2'b01;
         end
      end else begin
         if (load_out) begin
            PC             <= load_pc;
            instr          <= load_instr;
            pipeline_valid <= 1'b1;
         end else if (!stall) begin
            pipeline_valid <= 1'b0;
         end

         if (load_buf) begin
            buf_valid_q <= 1'b0;
         end

         case (state_q)
            StReq: begin
               // An outstanding request completes even under stall; its data is parked.
               if (take_rsp) begin
                  fetch_pc_q    <= fetch_pc_inc;
                  state_q       <= StGap;
                  mem_rd_enable <= 1'b0;
                  if (stall) begin
                     buf_valid_q <= 1'b1;
                     buf_pc_q    <= fetch_pc_q;
                     buf_instr_q <= mem_rd_data;
                  end
               end
            end
            StGap: begin
               if (!stall) begin
                  state_q       <= StReq;
                  mem_rd_enable <= 1'b1;
                  mem_rd_addr   <= fetch_pc_q;
               end
            end
            StHalt: begin
               mem_rd_enable <= 1'b0;
            end
            default: begin
               state_q       <= StGap;
               mem_rd_enable <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_TRACE_EN
   // Trace each instruction on the edge it is handed to decode.
   always_ff @(posedge clk) begin
      if (!reset && load_out) begin
         $display("FETCH pc=%h instr=%h", load_pc, load_instr);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit.
// Memory model answers with addr+0x8000 half a cycle after the request is seen,
// but only while it holds unused credits, so stimulus controls when data lands.
module tb_fetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PC;
   logic [31:0] instr;
   logic        pipeline_valid;
   logic        mem_rd_enable;
   logic [31:0] mem_rd_addr;
   logic        mem_rd_ready = 1'b0;
   logic [31:0] mem_rd_data = 32'hDEAD_BEEF;
   logic        stall;
   logic        flush;
   logic [31:0] flush_addr;
   logic [1:0]  exception;

   exp_t exp_q[$];
   int   pop_cyc[$];
   int   n_total = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   credits = 0;
   int   used = 0;
   logic last_stall = 1'b0;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .reset          (reset),
      .PC             (PC),
      .instr          (instr),
      .pipeline_valid (pipeline_valid),
      .mem_rd_enable  (mem_rd_enable),
      .mem_rd_addr    (mem_rd_addr),
      .mem_rd_ready   (mem_rd_ready),
      .mem_rd_data    (mem_rd_data),
      .stall          (stall),
      .flush          (flush),
      .flush_addr     (flush_addr),
      .exception      (exception)
   );

   initial forever #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic expect_out(input logic [31:0] pc, input logic [31:0] ins);
      exp_t e;
      e.pc  = pc;
      e.ins = ins;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
      n_total++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_reset_values();
      check32("rst_pc", PC, 32'h0);
      check32("rst_instr", instr, 32'h0);
      check32("rst_valid", {31'd0, pipeline_valid}, 32'h0);
      check32("rst_enable", {31'd0, mem_rd_enable}, 32'h0);
      check32("rst_addr", mem_rd_addr, 32'h0);
      check32("rst_exception", {30'd0, exception}, 32'h0);
   endtask

   // Memory: answer at the falling edge while a request is up and credit remains.
   initial forever begin
      @(negedge clk);
      if (mem_rd_enable === 1'b1 && used < credits) begin
         mem_rd_ready = 1'b1;
         mem_rd_data  = mem_rd_addr + 32'h8000;
      end else begin
         mem_rd_ready = 1'b0;
         mem_rd_data  = 32'hDEAD_BEEF;
      end
   end

   // Edge bookkeeping: cycle count, stall seen by the edge, responses consumed.
   initial forever begin
      @(posedge clk);
      cyc++;
      last_stall = stall;
      if (mem_rd_enable === 1'b1 && mem_rd_ready) used++;
   end

   // Monitor: every newly presented instruction is matched against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (pipeline_valid === 1'b1 && !last_stall) begin
            if (exp_q.size() == 0) begin
               n_total++;
               n_bad++;
               $display("FAIL unexpected_output: got pc=%h instr=%h expected none", PC, instr);
            end else begin
               e = exp_q.pop_front();
               check32("out_pc", PC, e.pc);
               check32("out_instr", instr, e.ins);
               pop_cyc.push_back(cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      stall      = 1'b0;
      flush      = 1'b0;
      flush_addr = 32'h0;

      // Reset for one cycle, then three back-to-back fetches.
      tick();
      check_reset_values();
      reset = 1'b0;
      expect_out(32'h0, 32'h8000);
      expect_out(32'h4, 32'h8004);
      expect_out(32'h8, 32'h8008);
      credits = 3;
      wait_drain(20);
      n_total++;
      if (pop_cyc.size() < 3) begin
         n_bad++;
         $display("FAIL valid_count: got %0d expected 3", pop_cyc.size());
      end else begin
         check32("valid_spacing_a", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
         check32("valid_spacing_b", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);
      end

      // Stall while the request for 0xC is outstanding; response gets buffered.
      tick();
      check32("pend_enable", {31'd0, mem_rd_enable}, 32'h1);
      check32("pend_addr", mem_rd_addr, 32'hC);
      stall   = 1'b1;
      credits = 4;
      expect_out(32'hC, 32'h800C);
      for (int i = 0; i < 3; i++) begin
         tick();
         check32("stall_pc", PC, 32'h8);
         check32("stall_instr", instr, 32'h8008);
         check32("stall_valid", {31'd0, pipeline_valid}, 32'h0);
      end
      check32("stall_enable", {31'd0, mem_rd_enable}, 32'h0);
      stall = 1'b0;
      wait_drain(10);
      tick();
      check32("post_stall_valid", {31'd0, pipeline_valid}, 32'h0);
      check32("post_stall_addr", mem_rd_addr, 32'h10);

      // Flush to 0x4 while the request for 0x10 is outstanding.
      flush      = 1'b1;
      flush_addr = 32'h4;
      tick();
      check32("flush_valid", {31'd0, pipeline_valid}, 32'h0);
      check32("flush_enable", {31'd0, mem_rd_enable}, 32'h0);
      check32("flush_exception", {30'd0, exception}, 32'h0);
      flush = 1'b0;
      expect_out(32'h4, 32'h8004);
      credits = 5;
      wait_drain(10);

      // Flush and stall together while ready is high: data dropped, redirect taken.
      tick();
      credits = 6;
      tick();
      flush      = 1'b1;
      stall      = 1'b1;
      flush_addr = 32'h20;
      tick();
      check32("fs_valid", {31'd0, pipeline_valid}, 32'h0);
      check32("fs_enable", {31'd0, mem_rd_enable}, 32'h0);
      flush = 1'b0;
      stall = 1'b0;
      expect_out(32'h20, 32'h8020);
      credits = 7;
      wait_drain(10);

      // Misaligned flush halts the unit until an aligned flush.
      tick();
      flush      = 1'b1;
      flush_addr = 32'h6;
      tick();
      check32("mis_exception", {30'd0, exception}, 32'h1);
      check32("mis_enable", {31'd0, mem_rd_enable}, 32'h0);
      check32("mis_valid", {31'd0, pipeline_valid}, 32'h0);
      flush   = 1'b0;
      credits = 8;
      for (int i = 0; i < 3; i++) begin
         tick();
         check32("halt_enable", {31'd0, mem_rd_enable}, 32'h0);
         check32("halt_exception", {30'd0, exception}, 32'h1);
      end
      flush      = 1'b1;
      flush_addr = 32'h10;
      tick();
      check32("unhalt_exception", {30'd0, exception}, 32'h0);
      flush = 1'b0;
      expect_out(32'h10, 32'h8010);
      wait_drain(10);

      // Reset lands on the same edge as a response.
      tick();
      credits = 9;
      tick();
      reset = 1'b1;
      tick();
      check_reset_values();
      reset = 1'b0;
      tick();
      check32("restart_enable", {31'd0, mem_rd_enable}, 32'h1);
      check32("restart_addr", mem_rd_addr, 32'h0);
      expect_out(32'h0, 32'h8000);
      credits = 10;
      wait_drain(10);

      tick();
      tick();
      check32("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
